// File: rtl/mire_pkg.sv
// Shared types and constants for the mire_wshb test-pattern generator.
package mire_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PAUSE
    } state_t;

    typedef enum logic [1:0] {
        MODE_GRID,
        MODE_BARS,
        MODE_GRAD,
        MODE_SOLID
    } mode_t;

    localparam pixel_t WHITE   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam pixel_t YELLOW  = '{r: 8'hFF, g: 8'hFF, b: 8'h00};
    localparam pixel_t CYAN    = '{r: 8'h00, g: 8'hFF, b: 8'hFF};
    localparam pixel_t GREEN   = '{r: 8'h00, g: 8'hFF, b: 8'h00};
    localparam pixel_t MAGENTA = '{r: 8'hFF, g: 8'h00, b: 8'hFF};
    localparam pixel_t RED     = '{r: 8'hFF, g: 8'h00, b: 8'h00};
    localparam pixel_t BLUE    = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam pixel_t BLACK   = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/mire_wshb_if.sv
// Wishbone classic write-master bundle between mire_wshb and the bus arbiter.
interface mire_wshb_if;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms,
        input  ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms,
        output ack, err
    );

endinterface

// File: rtl/mire_pattern.sv
// Combinational pattern generator: pixel colour from raster position and mode.
module mire_pattern
    import mire_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  mode_t         mode,
    output pixel_t        pix
);

    logic [2:0] bar;

    // A bar begins once x has passed its threshold, so the threshold column
    // itself still belongs to the previous bar.
    always_comb begin
        bar = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(x) > (k * HDISP) / 8) begin
                bar = bar + 3'd1;
            end
        end
    end

    always_comb begin
        pix = BLACK;
        unique case (mode)
            MODE_GRID: begin
                if ((x & XW'(4'hF)) == '0 || (y & YW'(4'hF)) == '0) begin
                    pix = WHITE;
                end
            end
            MODE_BARS: begin
                unique case (bar)
                    3'd0: pix = WHITE;
                    3'd1: pix = YELLOW;
                    3'd2: pix = CYAN;
                    3'd3: pix = GREEN;
                    3'd4: pix = MAGENTA;
                    3'd5: pix = RED;
                    3'd6: pix = BLUE;
                    3'd7: pix = BLACK;
                endcase
            end
            MODE_GRAD: begin
                pix.r = 8'(x);
                pix.g = 8'(y);
                pix.b = 8'(x) + 8'(y);
            end
            MODE_SOLID: pix = BLUE;
        endcase
    end

endmodule

// File: rtl/mire_wshb.sv
// Framebuffer test-pattern writer: one pixel per Wishbone write in raster order,
// dropping cyc for one cycle every RELEASE writes so the display reader can run.
module mire_wshb
    import mire_pkg::*;
#(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          RELEASE   = 64
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         enable,
    input  logic [1:0]   mode,
    output logic         frame_done,
    mire_wshb_if.master  wshb
);

    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);
    localparam int IW = $clog2(HDISP * VDISP);
    localparam int BW = $clog2(RELEASE + 1);

    state_t        state, state_n;
    mode_t         mode_q;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [IW-1:0] idx;
    logic [BW-1:0] burst;
    logic          frame_end;
    logic          stb_i;
    logic          start;
    logic          take;
    logic          last_px;
    logic          burst_last;
    pixel_t        pix;

    assign last_px    = (x == XW'(HDISP - 1)) && (y == YW'(VDISP - 1));
    assign burst_last = (burst == BW'(RELEASE - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        stb_i   = 1'b0;
        start   = 1'b0;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    start   = 1'b1;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                stb_i = 1'b1;
                if (wshb.err) begin
                    state_n = PAUSE;
                end else if (wshb.ack) begin
                    take = 1'b1;
                    if (burst_last || last_px) begin
                        state_n = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (frame_end && !enable) begin
                    state_n = IDLE;
                end else begin
                    start   = frame_end;
                    state_n = WRITE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q     <= MODE_GRID;
            x          <= '0;
            y          <= '0;
            idx        <= '0;
            burst      <= '0;
            frame_end  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= take && last_px;
            if (start) begin
                mode_q    <= mode_t'(mode);
                x         <= '0;
                y         <= '0;
                idx       <= '0;
                burst     <= '0;
                frame_end <= 1'b0;
            end else if (take) begin
                idx   <= idx + 1'b1;
                burst <= burst + 1'b1;
                if (x == XW'(HDISP - 1)) begin
                    x <= '0;
                    y <= last_px ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                if (last_px) begin
                    frame_end <= 1'b1;
                end
            end else if (state == PAUSE) begin
                burst <= '0;
            end
        end
    end

    mire_pattern #(
        .HDISP (HDISP),
        .XW    (XW),
        .YW    (YW)
    ) u_pattern (
        .x    (x),
        .y    (y),
        .mode (mode_q),
        .pix  (pix)
    );

    // Bus outputs are gated by stb so they read as zero outside a transfer.
    assign wshb.cyc    = stb_i;
    assign wshb.stb    = stb_i;
    assign wshb.we     = stb_i;
    assign wshb.sel    = stb_i ? 4'hF : 4'h0;
    assign wshb.adr    = stb_i ? BASE_ADDR + (32'(idx) << 2) : '0;
    assign wshb.dat_ms = stb_i ? {8'h00, pix} : '0;

endmodule

// File: tb/tb_mire_wshb.sv
// Directed bench for mire_wshb: zero-wait, wait-state, error, enable-drop,
// mode-switch and mid-burst reset frames checked against a pixel scoreboard.
module tb_mire_wshb;

    localparam int HD  = 16;
    localparam int VD  = 4;
    localparam int REL = 8;
    localparam int NPX = HD * VD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       frame_done;

    mire_wshb_if bus ();

    mire_wshb #(
        .HDISP     (HD),
        .VDISP     (VD),
        .BASE_ADDR (32'h0),
        .RELEASE   (REL)
    ) dut (
        .sys_clk    (clk),
        .sys_rst_n  (rst_n),
        .enable     (enable),
        .mode       (mode),
        .frame_done (frame_done),
        .wshb       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];
    logic [31:0] cap_x3y2, cap_x2, cap_x15, first_adr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input int x, input int y);
        logic [23:0] bars [8];
        int b;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        case (m)
            2'd0: return ((x % 16) == 0 || (y % 16) == 0) ? 32'h00FFFFFF : 32'h0;
            2'd1: begin
                b = (x == 0) ? 0 : ((x - 1) * 8) / HD;
                return {8'h00, bars[b]};
            end
            2'd2: return {8'h00, 8'(x & 255), 8'(y & 255), 8'((x + y) & 255)};
            default: return 32'h000000FF;
        endcase
    endfunction

    task automatic run_frame(input logic [1:0] m, input int wait_n, input int err_at,
                             input int drop_at, input int mode_at, input logic [1:0] mode_new,
                             input int abort_at);
        int acks = 0, tenure = 0, wcnt = 0;
        logic done = 0, last_prev = 0, was_err = 0, err_done = 0, pend = 0;
        logic [31:0] padr = '0, pdat = '0;
        logic [63:0] e;
        for (int yy = 0; yy < VD; yy++)
            for (int xx = 0; xx < HD; xx++)
                sb.push_back({32'((yy * HD + xx) * 4), model(m, xx, yy)});
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            bus.ack = 1'b0;
            bus.err = 1'b0;
            chk("frame_done", {31'b0, frame_done}, {31'b0, last_prev});
            last_prev = 1'b0;
            if (frame_done) begin
                done = 1'b1;
                chk("cyc_end", {31'b0, bus.cyc}, 32'd0);
            end else if (tenure == REL || was_err) begin
                chk("cyc_low", {31'b0, bus.cyc}, 32'd0);
                tenure = 0;
                was_err = 1'b0;
                pend = 1'b0;
            end else begin
                chk("cyc_high", {31'b0, bus.cyc}, 32'd1);
                if (pend) begin
                    chk("hold_adr", bus.adr, padr);
                    chk("hold_dat", bus.dat_ms, pdat);
                end
                if (abort_at == acks) begin
                    bus.ack = 1'b1;
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_cyc", {31'b0, bus.cyc}, 32'd0);
                    chk("rst_adr", bus.adr, 32'd0);
                    chk("rst_dat", bus.dat_ms, 32'd0);
                    @(negedge clk);
                    chk("rst_late_ack", {31'b0, bus.cyc}, 32'd0);
                    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
                    bus.ack = 1'b0;
                    rst_n = 1'b1;
                    sb.delete();
                    return;
                end
                if (err_at == acks && !err_done) begin
                    bus.err = 1'b1;
                    err_done = 1'b1;
                    was_err = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                    if (wcnt > wait_n) begin
                        bus.ack = 1'b1;
                        wcnt = 0;
                    end
                end
                if (bus.ack) begin
                    e = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                    chk("pix_adr", bus.adr, e[63:32]);
                    chk("pix_dat", bus.dat_ms, e[31:0]);
                    chk("pix_we_sel", {27'b0, bus.we, bus.sel}, 32'h1F);
                    if (acks == 0) first_adr = bus.adr;
                    if (bus.adr == 32'd140) cap_x3y2 = bus.dat_ms;
                    if (bus.adr == 32'd8) cap_x2 = bus.dat_ms;
                    if (bus.adr == 32'd60) cap_x15 = bus.dat_ms;
                    acks++;
                    tenure++;
                    if (acks == NPX) last_prev = 1'b1;
                    if (acks == drop_at) enable = 1'b0;
                    if (acks == mode_at) mode = mode_new;
                end
                pend = !bus.ack && !bus.err;
                padr = bus.adr;
                pdat = bus.dat_ms;
            end
        end
        chk("frame_seen", {31'b0, done}, 32'd1);
        chk("ack_total", acks, NPX);
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        int hi = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.cyc) hi++;
        end
        chk(tag, hi, 0);
    endtask

    initial begin
        bus.ack = 1'b0;
        bus.err = 1'b0;
        #1;
        chk("reset_ctl", {27'b0, bus.cyc, bus.stb, bus.we, frame_done, 1'b0}, 32'd0);
        chk("reset_sel", {28'b0, bus.sel}, 32'd0);
        chk("reset_adr", bus.adr, 32'd0);
        chk("reset_dat", bus.dat_ms, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(100, "idle_after_reset");

        mode = 2'd2;
        enable = 1'b1;
        run_frame(2'd2, 0, -1, -1, -1, 2'd0, -1);
        chk("first_adr", first_adr, 32'd0);
        chk("x3y2_dat", cap_x3y2, 32'h00030205);

        run_frame(2'd2, 2, -1, -1, -1, 2'd0, -1);
        run_frame(2'd2, 0, 5, -1, -1, 2'd0, -1);
        run_frame(2'd2, 0, -1, 20, -1, 2'd0, -1);
        idle_cycles(20, "idle_after_drop");

        mode = 2'd1;
        enable = 1'b1;
        run_frame(2'd1, 0, -1, -1, 10, 2'd0, -1);
        chk("bars_x2", cap_x2, 32'h00FFFFFF);
        chk("bars_x15", cap_x15, 32'h00000000);
        run_frame(2'd0, 0, -1, -1, -1, 2'd0, -1);

        run_frame(2'd0, 0, -1, -1, -1, 2'd0, 12);
        first_adr = 32'hFFFF_FFFF;
        run_frame(2'd0, 0, -1, 63, -1, 2'd0, -1);
        chk("restart_adr", first_adr, 32'd0);
        idle_cycles(10, "idle_at_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
